// File: rtl/cdi_rom_loader.sv
// rtl/cdi_rom_loader.sv - HPS ioctl byte stream to big-endian 16-bit ROM word store loader
module cdi_rom_loader #(
  parameter logic [7:0] ROM_INDEX  = 8'h00,
  parameter int         ROM_WORDS  = 262144,
  parameter int         RESET_HOLD = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_ioctl_download,
  input  logic [7:0]                    i_ioctl_index,
  input  logic                          i_ioctl_wr,
  input  logic [24:0]                   i_ioctl_addr,
  input  logic [7:0]                    i_ioctl_dout,
  output logic                          o_ioctl_wait,
  output logic                          o_rom_we,
  output logic [$clog2(ROM_WORDS)-1:0]  o_rom_addr,
  output logic [15:0]                   o_rom_wdata,
  input  logic                          i_rom_ready,
  output logic                          o_cpu_reset_hold,
  output logic                          o_rom_valid,
  output logic [15:0]                   o_rom_checksum,
  output logic                          o_rom_overflow
);

  localparam int          AW         = $clog2(ROM_WORDS);
  localparam int          HW         = $clog2(RESET_HOLD + 1);
  localparam logic [24:0] BYTE_LIMIT = 25'(2 * ROM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t          r_state;
  logic [7:0]      r_hi;
  logic            r_pending;
  logic [AW-1:0]   r_pend_addr;
  logic            r_second;
  logic [AW-1:0]   r_next_addr;
  logic [15:0]     r_next_data;
  logic            r_end;
  logic            r_any;
  logic [HW-1:0]   r_hold;
  logic            r_ioctl_wait;
  logic            r_rom_we;
  logic [AW-1:0]   r_rom_addr;
  logic [15:0]     r_rom_wdata;
  logic            r_rom_valid;
  logic [15:0]     r_checksum;
  logic            r_overflow;

  logic            w_active;
  logic            w_in_range;
  logic [AW-1:0]   w_word_addr;

  assign w_active    = i_ioctl_download && (i_ioctl_index == ROM_INDEX);
  assign w_in_range  = i_ioctl_addr < BYTE_LIMIT;
  assign w_word_addr = i_ioctl_addr[AW:1];

  // Loader state machine: byte pairing, store handshake, checksum and reset-hold timer
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_hi         <= 8'h00;
      r_pending    <= 1'b0;
      r_pend_addr  <= '0;
      r_second     <= 1'b0;
      r_next_addr  <= '0;
      r_next_data  <= 16'h0000;
      r_end        <= 1'b0;
      r_any        <= 1'b0;
      r_hold       <= '0;
      r_ioctl_wait <= 1'b0;
      r_rom_we     <= 1'b0;
      r_rom_addr   <= '0;
      r_rom_wdata  <= 16'h0000;
      r_rom_valid  <= 1'b0;
      r_checksum   <= 16'h0000;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_hold != '0) r_hold <= r_hold - 1'b1;
          if (w_active) begin
            r_rom_valid <= 1'b0;
            r_checksum  <= 16'h0000;
            r_overflow  <= 1'b0;
            r_pending   <= 1'b0;
            r_any       <= 1'b0;
            r_second    <= 1'b0;
            r_end       <= 1'b0;
            r_state     <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (!w_active) begin
            // Transfer ended: a lone high byte still has to reach the store
            if (r_pending) begin
              r_rom_addr   <= r_pend_addr;
              r_rom_wdata  <= {r_hi, 8'hFF};
              r_rom_we     <= 1'b1;
              r_ioctl_wait <= 1'b1;
              r_end        <= 1'b1;
              r_state      <= S_WRITE;
            end else begin
              r_state <= S_FINISH;
            end
          end else if (i_ioctl_wr) begin
            if (!w_in_range) begin
              r_overflow <= 1'b1;
            end else if (!i_ioctl_addr[0]) begin
              r_hi        <= i_ioctl_dout;
              r_pending   <= 1'b1;
              r_pend_addr <= w_word_addr;
            end else begin
              r_rom_we     <= 1'b1;
              r_ioctl_wait <= 1'b1;
              r_state      <= S_WRITE;
              if (r_pending && (r_pend_addr != w_word_addr)) begin
                // Orphaned high byte goes out first, the odd byte's word queues behind it
                r_rom_addr  <= r_pend_addr;
                r_rom_wdata <= {r_hi, 8'hFF};
                r_second    <= 1'b1;
                r_next_addr <= w_word_addr;
                r_next_data <= {8'hFF, i_ioctl_dout};
              end else begin
                r_rom_addr  <= w_word_addr;
                r_rom_wdata <= {(r_pending ? r_hi : 8'hFF), i_ioctl_dout};
              end
            end
          end
        end

        S_WRITE: begin
          if (i_rom_ready) begin
            r_checksum <= r_checksum + r_rom_wdata;
            r_any      <= 1'b1;
            r_pending  <= 1'b0;
            if (r_second) begin
              r_second    <= 1'b0;
              r_rom_addr  <= r_next_addr;
              r_rom_wdata <= r_next_data;
            end else begin
              r_rom_we     <= 1'b0;
              r_ioctl_wait <= 1'b0;
              r_state      <= r_end ? S_FINISH : S_COLLECT;
            end
          end
        end

        S_FINISH: begin
          r_rom_valid <= !r_overflow && r_any;
          r_hold      <= HW'(RESET_HOLD);
          r_end       <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ioctl_wait     = r_ioctl_wait;
  assign o_rom_we         = r_rom_we;
  assign o_rom_addr       = r_rom_addr;
  assign o_rom_wdata      = r_rom_wdata;
  assign o_rom_valid      = r_rom_valid;
  assign o_rom_checksum   = r_checksum;
  assign o_rom_overflow   = r_overflow;
  assign o_cpu_reset_hold = !r_rom_valid || (r_state != S_IDLE) || (r_hold != '0);

endmodule

// File: tb/tb_cdi_rom_loader.sv
// tb/tb_cdi_rom_loader.sv - directed self-checking bench for cdi_rom_loader
module tb_cdi_rom_loader;

  localparam int ROM_WORDS = 262144;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rom_we;
  logic [17:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        rom_ready;
  logic        cpu_reset_hold;
  logic        rom_valid;
  logic [15:0] rom_checksum;
  logic        rom_overflow;

  int total = 0;
  int bad   = 0;

  logic [33:0] wq[$];

  cdi_rom_loader dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_ioctl_download (ioctl_download),
    .i_ioctl_index    (ioctl_index),
    .i_ioctl_wr       (ioctl_wr),
    .i_ioctl_addr     (ioctl_addr),
    .i_ioctl_dout     (ioctl_dout),
    .o_ioctl_wait     (ioctl_wait),
    .o_rom_we         (rom_we),
    .o_rom_addr       (rom_addr),
    .o_rom_wdata      (rom_wdata),
    .i_rom_ready      (rom_ready),
    .o_cpu_reset_hold (cpu_reset_hold),
    .o_rom_valid      (rom_valid),
    .o_rom_checksum   (rom_checksum),
    .o_rom_overflow   (rom_overflow)
  );

  always #5 clk = ~clk;

  // Record every accepted store write as {addr, data}
  always @(negedge clk) begin
    if (rom_we && rom_ready) wq.push_back({rom_addr, rom_wdata});
  end

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, output logic we_after);
    int n;
    @(posedge clk); #1;
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    we_after = rom_we;
    n = 0;
    while (ioctl_wait && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("wait_bound", 34'(n), 34'd49);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(posedge clk); #1;
    ioctl_download = 1'b1; ioctl_index = idx;
    @(posedge clk); #1;
  endtask

  task automatic end_dl();
    @(posedge clk); #1;
    ioctl_download = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    logic w;
    int   base, n, m, n_we, n_st;

    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = 8'h00; rom_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", rom_we, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_wdata", rom_wdata, 0);
    chk("rst_valid", rom_valid, 0);
    chk("rst_sum", rom_checksum, 0);
    chk("rst_ovf", rom_overflow, 0);
    chk("rst_hold", cpu_reset_hold, 1);
    reset = 1'b0;

    // Basic 4-byte image
    base = wq.size();
    start_dl(8'h00);
    send_byte(25'd0, 8'h12, w); chk("t1_lat_even", w, 0);
    send_byte(25'd1, 8'h34, w); chk("t1_lat_odd1", w, 1);
    send_byte(25'd2, 8'h56, w);
    send_byte(25'd3, 8'h78, w); chk("t1_lat_odd3", w, 1);
    @(posedge clk); #1;
    ioctl_download = 1'b0;
    n = 0;
    while (!rom_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_valid", rom_valid, 1);
    m = 0;
    while (cpu_reset_hold && m < 100) begin
      m++;
      @(negedge clk);
    end
    chk("t1_hold_cycles", 34'(m), 34'd16);
    chk("t1_nwr", 34'(wq.size() - base), 34'd2);
    chk("t1_w0", wq[base], {18'd0, 16'h1234});
    chk("t1_w1", wq[base+1], {18'd1, 16'h5678});
    chk("t1_sum", rom_checksum, 16'h68AC);
    chk("t1_ovf", rom_overflow, 0);

    // Store back-pressure on the first word
    base = wq.size();
    start_dl(8'h00);
    chk("t2_valid_drop", rom_valid, 0);
    send_byte(25'd0, 8'h12, w);
    rom_ready = 1'b0;
    @(posedge clk); #1;
    ioctl_wr = 1'b1; ioctl_addr = 25'd1; ioctl_dout = 8'h34;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    n_we = 0; n_st = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rom_we && ioctl_wait) n_we++;
      if (rom_addr == 18'd0 && rom_wdata == 16'h1234) n_st++;
    end
    @(posedge clk); #1;
    rom_ready = 1'b1;
    @(negedge clk);
    if (rom_we && ioctl_wait) n_we++;
    if (rom_addr == 18'd0 && rom_wdata == 16'h1234) n_st++;
    @(negedge clk);
    chk("t2_we_cycles", 34'(n_we), 34'd6);
    chk("t2_stable", 34'(n_st), 34'd6);
    chk("t2_we_low", rom_we, 0);
    chk("t2_wait_low", ioctl_wait, 0);
    send_byte(25'd2, 8'h56, w);
    send_byte(25'd3, 8'h78, w);
    end_dl();
    chk("t2_nwr", 34'(wq.size() - base), 34'd2);
    chk("t2_w0", wq[base], {18'd0, 16'h1234});
    chk("t2_w1", wq[base+1], {18'd1, 16'h5678});
    chk("t2_sum", rom_checksum, 16'h68AC);
    chk("t2_valid", rom_valid, 1);

    // Odd-length image: trailing high byte flushed at end of transfer
    base = wq.size();
    start_dl(8'h00);
    send_byte(25'd0, 8'hAA, w);
    send_byte(25'd1, 8'hBB, w);
    send_byte(25'd2, 8'hCC, w); chk("t3_no_wr_even", w, 0);
    end_dl();
    chk("t3_nwr", 34'(wq.size() - base), 34'd2);
    chk("t3_w0", wq[base], {18'd0, 16'hAABB});
    chk("t3_w1", wq[base+1], {18'd1, 16'hCCFF});
    chk("t3_sum", rom_checksum, 16'h77BA);
    chk("t3_valid", rom_valid, 1);

    // Byte beyond capacity
    base = wq.size();
    start_dl(8'h00);
    send_byte(25'd0, 8'h01, w);
    send_byte(25'd1, 8'h02, w);
    send_byte(25'(2 * ROM_WORDS) + 25'd1, 8'h55, w); chk("t4_no_we", w, 0);
    @(negedge clk);
    chk("t4_ovf", rom_overflow, 1);
    chk("t4_no_wait", ioctl_wait, 0);
    end_dl();
    chk("t4_nwr", 34'(wq.size() - base), 34'd1);
    chk("t4_valid", rom_valid, 0);
    m = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cpu_reset_hold) m++;
    end
    chk("t4_hold_stays", 34'(m), 34'd30);

    // Odd byte for a different word than the pending high byte
    base = wq.size();
    start_dl(8'h00);
    send_byte(25'd0, 8'h11, w);
    send_byte(25'd3, 8'h22, w);
    end_dl();
    chk("t5_nwr", 34'(wq.size() - base), 34'd2);
    chk("t5_w0", wq[base], {18'd0, 16'h11FF});
    chk("t5_w1", wq[base+1], {18'd1, 16'hFF22});
    chk("t5_sum", rom_checksum, 16'h1121);

    // Checksum wrap
    start_dl(8'h00);
    send_byte(25'd0, 8'hFF, w);
    send_byte(25'd1, 8'hFF, w);
    send_byte(25'd2, 8'h00, w);
    send_byte(25'd3, 8'h02, w);
    end_dl();
    chk("t6_sum", rom_checksum, 16'h0001);
    chk("t6_valid", rom_valid, 1);

    // Transfer for another index is ignored
    base = wq.size();
    start_dl(8'h01);
    send_byte(25'd0, 8'hAA, w);
    send_byte(25'd1, 8'hBB, w); chk("t7_no_we", w, 0);
    end_dl();
    chk("t7_nwr", 34'(wq.size() - base), 34'd0);
    chk("t7_valid", rom_valid, 1);
    chk("t7_sum", rom_checksum, 16'h0001);
    chk("t7_hold", cpu_reset_hold, 0);

    // Reset in the middle of a download
    start_dl(8'h00);
    send_byte(25'd0, 8'h12, w);
    send_byte(25'd1, 8'h34, w);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t8_we", rom_we, 0);
    chk("t8_wait", ioctl_wait, 0);
    chk("t8_addr", rom_addr, 0);
    chk("t8_wdata", rom_wdata, 0);
    chk("t8_valid", rom_valid, 0);
    chk("t8_sum", rom_checksum, 0);
    chk("t8_hold", cpu_reset_hold, 1);
    reset = 1'b0; ioctl_download = 1'b0;
    repeat (5) @(negedge clk);
    chk("t8_valid_after", rom_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
